// File: rtl/nes_pad_reader_pkg.sv
// NES controller reader: shared state encoding and button bit positions.
// Bit 7 of the button byte is A, bit 0 is right (controller shift order).
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [2:0] BTN_A      = 3'd7;
    localparam logic [2:0] BTN_B      = 3'd6;
    localparam logic [2:0] BTN_SELECT = 3'd5;
    localparam logic [2:0] BTN_START  = 3'd4;
    localparam logic [2:0] BTN_UP     = 3'd3;
    localparam logic [2:0] BTN_DOWN   = 3'd2;
    localparam logic [2:0] BTN_LEFT   = 3'd1;
    localparam logic [2:0] BTN_RIGHT  = 3'd0;

    // Shift slot for the idx-th serial bit: first bit out is A.
    function automatic logic [2:0] btn_slot(input logic [2:0] idx);
        return BTN_A - idx;
    endfunction

endpackage

// File: rtl/nes_pad_if.sv
// NES controller wire bundle: latch and clock to the pad, data back.
// master = reader (drives latch/clk), slave = controller (drives data).
interface nes_pad_if;

    logic pad_latch;
    logic pad_clk;
    logic pad_data;

    modport master (
        output pad_latch,
        output pad_clk,
        input  pad_data
    );

    modport slave (
        input  pad_latch,
        input  pad_clk,
        output pad_data
    );

endinterface

// File: rtl/nes_half_period_timer.sv
// Down-counter for pad bit timing. load: reload with load_val.
// count: enable; tc: high on the last cycle (counter at zero), no wrap.
module nes_half_period_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = count && (cnt_q == '0);

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: latch, 8 shift clocks, edge-detected report.
// Ports: clk, rst_n (sync), poll, pad (latch/clk/data), buttons,
// pressed, released, valid, busy.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int HALF_PERIOD = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll,
    nes_pad_if.master   pad,
    output logic [7:0]  buttons,
    output logic [7:0]  pressed,
    output logic [7:0]  released,
    output logic        valid,
    output logic        busy
);

    localparam int CW = $clog2(HALF_PERIOD * 2);
    localparam logic [CW-1:0] LATCH_LD = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LD  = CW'(HALF_PERIOD - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buttons_q, buttons_d;
    logic [7:0] pressed_q, pressed_d;
    logic [7:0] released_q, released_d;
    logic       valid_q, valid_d;
    logic       latch_q, latch_d;
    logic       pclk_q, pclk_d;

    logic          tmr_load;
    logic          tmr_tc;
    logic [CW-1:0] tmr_val;

    // Every transition is a state change, so reload on any change.
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        unique case (1'b1)
            (state_d == ST_LATCH): tmr_val = LATCH_LD;
            (state_d == ST_LOW),
            (state_d == ST_HIGH):  tmr_val = HALF_LD;
            default:               tmr_val = '0;
        endcase
    end

    nes_half_period_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .count    (busy),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
        pressed_d  = '0;
        released_d = '0;
        valid_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (poll) begin
                    state_d = ST_LATCH;
                    idx_d   = '0;
                end
            end
            ST_LATCH: begin
                if (tmr_tc) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (tmr_tc) begin
                    shift_d[btn_slot(idx_q)] = ~pad.pad_data;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_tc) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        // Report regs load on DONE entry so the
                        // new byte and valid coincide with DONE.
                        state_d    = ST_DONE;
                        buttons_d  = shift_q;
                        pressed_d  = shift_q & ~buttons_q;
                        released_d = ~shift_q & buttons_q;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad strobes follow the next state so they line up with it.
    assign latch_d = (state_d == ST_LATCH);
    assign pclk_d  = (state_d == ST_HIGH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            valid_q    <= 1'b0;
            latch_q    <= 1'b0;
            pclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            valid_q    <= valid_d;
            latch_q    <= latch_d;
            pclk_q     <= pclk_d;
        end
    end

    assign pad.pad_latch = latch_q;
    assign pad.pad_clk   = pclk_q;
    assign buttons       = buttons_q;
    assign pressed       = pressed_q;
    assign released      = released_q;
    assign valid         = valid_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader with a behavioural pad model.
// Expected reports come from the presented button byte and prior report.
module tb_nes_pad_reader;

    localparam int HP = 4;
    localparam int READ_CYC = 18 * HP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] buttons, pressed, released;
    logic       valid, busy;

    nes_pad_if pad ();

    nes_pad_reader #(
        .HALF_PERIOD (HP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .poll     (poll),
        .pad      (pad.master),
        .buttons  (buttons),
        .pressed  (pressed),
        .released (released),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pad model: latch resets the bit pointer, each pad_clk rise advances.
    logic [7:0] pad_btn = 8'h00;
    bit         pad_tied = 1'b0;
    int         n_clk = 0;

    always @(posedge pad.pad_latch or posedge pad.pad_clk) begin
        if (pad.pad_latch) n_clk = 0;
        else n_clk = n_clk + 1;
    end

    always_comb begin
        pad.pad_data = 1'b1;
        if (!pad_tied && n_clk < 8)
            pad.pad_data = ~pad_btn[3'(7 - n_clk)];
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_glitch = 0;
    int exp_valid = 0;
    logic [7:0] model_btn = 8'h00;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (!valid && (pressed != 8'h00 || released != 8'h00))
            n_glitch++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_report(input string tag, input logic [7:0] b);
        check({tag, "_buttons"}, buttons, b);
        check({tag, "_pressed"}, pressed, b & ~model_btn);
        check({tag, "_released"}, released, ~b & model_btn);
        model_btn = b;
        exp_valid++;
    endtask

    task automatic do_read(input string tag, input logic [7:0] b,
                           input bit tied, input int rp1, input int rp2);
        int k, lat_hi, pulses, width, bad_w, bad_atomic;
        bit got, prev_clk;
        logic [7:0] exp_b;
        k = 0; lat_hi = 0; pulses = 0; width = 0; bad_w = 0;
        bad_atomic = 0; got = 0; prev_clk = 0;
        pad_btn = b;
        pad_tied = tied;
        exp_b = tied ? 8'h00 : b;
        @(negedge clk);
        poll = 1'b1;
        while (!got && k < READ_CYC + 20) begin
            @(negedge clk);
            k++;
            poll = (k == rp1 || k == rp2);
            if (k == 5) check({tag, "_busy"}, busy, 1);
            if (pad.pad_latch) lat_hi++;
            if (pad.pad_clk) width++;
            if (prev_clk && !pad.pad_clk) begin
                pulses++;
                if (width != HP) bad_w++;
                width = 0;
            end
            prev_clk = pad.pad_clk;
            if (valid) got = 1;
            else if (buttons !== model_btn) bad_atomic++;
        end
        poll = 1'b0;
        check({tag, "_valid"}, got, 1);
        check({tag, "_latency"}, k, READ_CYC + 1);
        check({tag, "_latch_cyc"}, lat_hi, 2 * HP);
        check({tag, "_clk_pulses"}, pulses, 8);
        check({tag, "_clk_width"}, bad_w, 0);
        check({tag, "_atomic"}, bad_atomic, 0);
        check_report(tag, exp_b);
        @(negedge clk);
        check({tag, "_valid_1cyc"}, valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_valid(input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid && k < READ_CYC + 20);
        check({tag, "_timeout"}, valid, 1);
    endtask

    initial begin
        int k;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_buttons", buttons, 0);
        check("rst_pressed", pressed, 0);
        check("rst_released", released, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_latch", pad.pad_latch, 0);
        check("rst_clk", pad.pad_clk, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_read("a_right", 8'h81, 0, -1, -1);
        do_read("right", 8'h01, 0, -1, -1);
        do_read("tied0", 8'h5A, 1, -1, -1);
        do_read("tied1", 8'hA5, 1, -1, -1);
        do_read("repoll", 8'h3C, 0, 10, 40);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            do_read("rand", b, 0, -1, -1);
        end

        // Reset in the middle of a read aborts it silently.
        pad_btn = 8'hFF;
        pad_tied = 0;
        @(negedge clk);
        poll = 1'b1;
        @(negedge clk);
        poll = 1'b0;
        repeat (28) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_latch", pad.pad_latch, 0);
        check("abort_clk", pad.pad_clk, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_buttons", buttons, 0);
        rst_n = 1'b1;
        model_btn = 8'h00;
        @(negedge clk);
        do_read("post_rst", 8'h42, 0, -1, -1);

        // Continuous poll: one idle cycle between DONE and next LATCH.
        b = 8'($urandom);
        pad_btn = b;
        @(negedge clk);
        poll = 1'b1;
        wait_valid("b2b_first", k);
        check_report("b2b_first", b);
        @(negedge clk);
        check("b2b_idle", busy, 0);
        @(negedge clk);
        check("b2b_restart", busy, 1);
        check("b2b_latch", pad.pad_latch, 1);
        wait_valid("b2b_second", k);
        check("b2b_gap", k, READ_CYC);
        check_report("b2b_second", b);
        poll = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_stop", busy, 0);

        check("valid_count", n_valid, exp_valid);
        check("pulse_glitch", n_glitch, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
